alu_arbiter: RTL and testbench

- Shares one 8-bit alu instance (SET/NOT/ADD/SUB, C/Z/S flags) between two requesters, e.g. the grom8 core execute stage and a DMA/checksum engine.
- Round-robin arbitration with a valid/ready request handshake.
- Registered inputs to the ALU, registered response.
- Keeps a private C/Z/S flag context per requester, so the two streams never corrupt each other's flags.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu.sv | 38 +++
 rtl/rr_arb2.sv | 45 ++++
 rtl/alu_arbiter.sv | 108 ++++++++++
 tb/tb_alu_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, flag vector, requester id width.
package alu_pkg;

    localparam logic [3:0] ALU_OP_SET = 4'd0;
    localparam logic [3:0] ALU_OP_NOT = 4'd1;
    localparam logic [3:0] ALU_OP_ADD = 4'd2;
    localparam logic [3:0] ALU_OP_SUB = 4'd3;

    localparam int ID_W = 1;

    typedef struct packed {
        logic c;
        logic z;
        logic s;
    } flags_t;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } req_t;

endpackage

// File: rtl/alu.sv
// 8-bit ALU: SET/NOT/ADD/SUB with C/Z/S flags; unknown ops give 0 and err.
module alu
    import alu_pkg::*;
(
    input  logic [3:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] result,
    output flags_t     flags,
    output logic       err
);

    logic [8:0] sum;

    always_comb begin
        sum    = '0;
        result = '0;
        err    = 1'b0;
        case (op)
            ALU_OP_SET: result = b;
            ALU_OP_NOT: result = ~a;
            ALU_OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[7:0];
            end
            // 9th bit of the subtraction is the borrow
            ALU_OP_SUB: begin
                sum    = {1'b0, a} - {1'b0, b};
                result = sum[7:0];
            end
            default: err = 1'b1;
        endcase
        flags.c = sum[8];
        flags.z = (result == 8'h00);
        flags.s = result[7];
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with last-grant pointer and optional lock hold.
module rr_arb2
    import alu_pkg::*;
#(
    parameter logic [ID_W-1:0] RESET_PTR = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic [1:0] lock,
    output logic [1:0] grant
);

    logic [ID_W-1:0] ptr;
    logic [1:0]      seen;

    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            case (valid)
                2'b01: grant = 2'b01;
                2'b10: grant = 2'b10;
                2'b11: begin
                    // lock only sticks once its owner has actually been granted
                    if (lock[ptr] && seen[ptr])
                        grant = ptr ? 2'b10 : 2'b01;
                    else
                        grant = ptr ? 2'b01 : 2'b10;
                end
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr  <= RESET_PTR;
            seen <= 2'b00;
        end else if (|grant) begin
            ptr  <= grant[1];
            seen <= seen | grant;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with per-requester C/Z/S contexts.
// Define ALU_ARB_LOCK_EN to add lock0/lock1 for atomic multi-op sequences.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter logic [ID_W-1:0] RESET_PTR  = 1'b1,
    parameter logic [2:0]      FLAG_RESET = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
`ifdef ALU_ARB_LOCK_EN
    input  logic       lock0,
    input  logic       lock1,
`endif
    input  logic       req0_valid,
    input  logic [3:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       req1_ready,
    output logic       resp_valid,
    output logic       resp_id,
    output logic [7:0] resp_result,
    output logic       resp_c,
    output logic       resp_z,
    output logic       resp_s,
    output logic       resp_err
);

    logic [1:0]      grant;
    logic [1:0]      lock;
    req_t            stg;
    logic [ID_W-1:0] stg_id;
    logic            stg_vld;
    flags_t [1:0]    ctx;
    flags_t          alu_flags;
    flags_t          resp_flags;
    logic [7:0]      alu_result;
    logic            alu_err;
    logic            is_arith;

`ifdef ALU_ARB_LOCK_EN
    assign lock = {lock1, lock0};
`else
    assign lock = 2'b00;
`endif

    rr_arb2 #(.RESET_PTR(RESET_PTR)) u_arb (
        .clk   (clk),
        .reset (reset),
        .valid ({req1_valid, req0_valid}),
        .lock  (lock),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    alu u_alu (
        .op     (stg.op),
        .a      (stg.a),
        .b      (stg.b),
        .result (alu_result),
        .flags  (alu_flags),
        .err    (alu_err)
    );

    assign is_arith = !alu_err && (stg.op == ALU_OP_ADD || stg.op == ALU_OP_SUB);

    // SET/NOT/illegal report the owner's untouched context
    always_comb begin
        resp_flags = ctx[stg_id];
        if (is_arith)
            resp_flags = alu_flags;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stg     <= '{op: ALU_OP_SET, a: 8'h00, b: 8'h00};
            stg_id  <= '0;
            stg_vld <= 1'b0;
            ctx     <= {2{flags_t'(FLAG_RESET)}};
        end else begin
            stg_vld <= |grant;
            if (|grant) begin
                stg    <= grant[1] ? req_t'{req1_op, req1_a, req1_b}
                                   : req_t'{req0_op, req0_a, req0_b};
                stg_id <= grant[1];
            end
            if (stg_vld && is_arith)
                ctx[stg_id] <= alu_flags;
        end
    end

    // a reset landing in the response cycle discards the in-flight op
    assign resp_valid  = stg_vld && !reset;
    assign resp_id     = stg_id;
    assign resp_result = alu_result;
    assign resp_err    = alu_err;
    assign resp_c      = resp_flags.c;
    assign resp_z      = resp_flags.z;
    assign resp_s      = resp_flags.s;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: handshake, flags contexts, fairness, reset, lock.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_ready, req1_ready;
    logic       resp_valid, resp_id, resp_c, resp_z, resp_s, resp_err;
    logic [7:0] resp_result;
`ifdef ALU_ARB_LOCK_EN
    logic       lock0, lock1;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.RESET_PTR(1'b1), .FLAG_RESET(3'b000)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef ALU_ARB_LOCK_EN
        .lock0       (lock0),
        .lock1       (lock1),
`endif
        .req0_valid  (req0_valid),
        .req0_op     (req0_op),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_op     (req1_op),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_ready  (req1_ready),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_c      (resp_c),
        .resp_z      (resp_z),
        .resp_s      (resp_s),
        .resp_err    (resp_err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive just after the edge, then let combinational outputs settle
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #3;
    endtask

    task automatic r0(input logic v, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic r1(input logic v, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    endtask

    task automatic resp(input string tag, input logic id, input logic [7:0] res, input logic [2:0] czs, input logic err);
        chk({tag, ".valid"}, {7'd0, resp_valid}, 8'd1);
        chk({tag, ".id"}, {7'd0, resp_id}, {7'd0, id});
        chk({tag, ".result"}, resp_result, res);
        chk({tag, ".czs"}, {5'd0, resp_c, resp_z, resp_s}, {5'd0, czs});
        chk({tag, ".err"}, {7'd0, resp_err}, {7'd0, err});
    endtask

    task automatic rdy(input string tag, input logic e0, input logic e1);
        chk(tag, {6'd0, req1_ready, req0_ready}, {6'd0, e1, e0});
    endtask

    task automatic do_reset;
        reset = 1'b1;
        r0(1'b0, 4'd0, 8'h00, 8'h00);
        r1(1'b0, 4'd0, 8'h00, 8'h00);
        tick; tick;
        reset = 1'b0;
    endtask

    initial begin
`ifdef ALU_ARB_LOCK_EN
        lock0 = 1'b0; lock1 = 1'b0;
`endif
        reset = 1'b1;
        r0(1'b0, 4'd0, 8'h00, 8'h00);
        r1(1'b0, 4'd0, 8'h00, 8'h00);
        tick;
        r0(1'b1, 4'd2, 8'h01, 8'h01);
        settle;
        rdy("rst.ready", 1'b0, 1'b0);
        r0(1'b0, 4'd0, 8'h00, 8'h00);
        tick;
        reset = 1'b0;
        settle;
        chk("rst.valid", {7'd0, resp_valid}, 8'd0);
        chk("rst.id", {7'd0, resp_id}, 8'd0);
        chk("rst.result", resp_result, 8'h00);
        chk("rst.err", {7'd0, resp_err}, 8'd0);
        chk("rst.czs", {5'd0, resp_c, resp_z, resp_s}, 8'd0);

        // req0 ADD 7F+01
        tick;
        r0(1'b1, 4'd2, 8'h7F, 8'h01);
        settle;
        rdy("add.ready", 1'b1, 1'b0);
        tick;
        r0(1'b0, 4'd0, 8'h00, 8'h00);
        settle;
        resp("add7f", 1'b0, 8'h80, 3'b001, 1'b0);

        // req1 SUB 5-5 then SET 0x33
        tick;
        r1(1'b1, 4'd3, 8'h05, 8'h05);
        settle;
        rdy("sub.ready", 1'b0, 1'b1);
        tick;
        r1(1'b1, 4'd0, 8'h00, 8'h33);
        settle;
        resp("sub", 1'b1, 8'h00, 3'b010, 1'b0);
        rdy("set.ready", 1'b0, 1'b1);
        tick;
        r1(1'b0, 4'd0, 8'h00, 8'h00);
        settle;
        resp("set1", 1'b1, 8'h33, 3'b010, 1'b0);
        tick;
        settle;
        chk("idle.valid", {7'd0, resp_valid}, 8'd0);
        chk("idle.hold", resp_result, 8'h33);

        // context isolation from fresh contexts
        do_reset;
        r0(1'b1, 4'd2, 8'hFF, 8'h01);
        settle;
        rdy("wrap.ready", 1'b1, 1'b0);
        tick;
        r0(1'b0, 4'd0, 8'h00, 8'h00);
        r1(1'b1, 4'd1, 8'h0F, 8'h00);
        settle;
        resp("wrap", 1'b0, 8'h00, 3'b110, 1'b0);
        rdy("not.ready", 1'b0, 1'b1);
        tick;
        r1(1'b0, 4'd0, 8'h00, 8'h00);
        r0(1'b1, 4'd0, 8'h00, 8'h5A);
        settle;
        resp("not1", 1'b1, 8'hF0, 3'b000, 1'b0);
        tick;
        r0(1'b1, 4'd6, 8'h12, 8'h34);
        settle;
        resp("set0", 1'b0, 8'h5A, 3'b110, 1'b0);
        tick;
        r0(1'b0, 4'd0, 8'h00, 8'h00);
        settle;
        resp("illegal", 1'b0, 8'h00, 3'b110, 1'b1);

        // fairness with both requesters continuously valid
        do_reset;
        r0(1'b1, 4'd2, 8'h01, 8'h01);
        r1(1'b1, 4'd2, 8'h10, 8'h10);
        settle;
        rdy("rr.g0", 1'b1, 1'b0);
        tick; settle;
        rdy("rr.g1", 1'b0, 1'b1);
        resp("rr.r0", 1'b0, 8'h02, 3'b000, 1'b0);
        tick; settle;
        rdy("rr.g2", 1'b1, 1'b0);
        resp("rr.r1", 1'b1, 8'h20, 3'b000, 1'b0);
        tick; settle;
        rdy("rr.g3", 1'b0, 1'b1);
        resp("rr.r2", 1'b0, 8'h02, 3'b000, 1'b0);
        tick;
        r0(1'b0, 4'd0, 8'h00, 8'h00);
        r1(1'b0, 4'd0, 8'h00, 8'h00);
        settle;
        resp("rr.r3", 1'b1, 8'h20, 3'b000, 1'b0);

        // reset lands in the response cycle of an accepted ADD
        do_reset;
        r0(1'b1, 4'd2, 8'hFF, 8'h01);
        settle;
        rdy("mid.ready", 1'b1, 1'b0);
        tick;
        reset = 1'b1;
        r1(1'b1, 4'd0, 8'h00, 8'h44);
        settle;
        chk("mid.valid", {7'd0, resp_valid}, 8'd0);
        rdy("mid.rst_ready", 1'b0, 1'b0);
        r0(1'b0, 4'd0, 8'h00, 8'h00);
        r1(1'b0, 4'd0, 8'h00, 8'h00);
        tick;
        reset = 1'b0;
        r0(1'b1, 4'd0, 8'h00, 8'h77);
        settle;
        chk("mid.after", {7'd0, resp_valid}, 8'd0);
        tick;
        r0(1'b0, 4'd0, 8'h00, 8'h00);
        settle;
        resp("mid.first", 1'b0, 8'h77, 3'b000, 1'b0);

`ifdef ALU_ARB_LOCK_EN
        do_reset;
        lock0 = 1'b1;
        r0(1'b1, 4'd2, 8'h01, 8'h02);
        r1(1'b1, 4'd2, 8'h03, 8'h04);
        settle;
        rdy("lock.g0", 1'b1, 1'b0);
        tick; settle;
        rdy("lock.g1", 1'b1, 1'b0);
        tick; settle;
        rdy("lock.g2", 1'b1, 1'b0);
        lock0 = 1'b0;
        r0(1'b0, 4'd0, 8'h00, 8'h00);
        r1(1'b0, 4'd0, 8'h00, 8'h00);
`endif

        tick;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
